// File: rtl/connect4_pkg.sv
// Shared encodings and board constants for the Connect4 game sequencer.
package connect4_pkg;

    localparam int unsigned CELLS_NUMBER = 42;
    localparam int unsigned NUM_COLS     = 7;
    localparam int unsigned NUM_ROWS     = 6;

    typedef enum logic [1:0] {
        GAME_INIT = 2'b00,
        P1_TURN   = 2'b01,
        P2_TURN   = 2'b10,
        END_GAME  = 2'b11
    } game_state_e;

    typedef enum logic [1:0] {
        PH_IDLE      = 2'b00,
        PH_WAIT_MOVE = 2'b01,
        PH_DROP      = 2'b10,
        PH_CHECK     = 2'b11
    } phase_e;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    function automatic game_state_e other_player(input game_state_e s);
        return (s == P1_TURN) ? P2_TURN : P1_TURN;
    endfunction

endpackage

// File: rtl/turn_timer.sv
// Per-turn idle counter: counts while enabled, flags the cycle it would reach LIMIT.
module turn_timer #(
    parameter int unsigned LIMIT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [31:0] count_q, count_d;

    // A clear in the same cycle (a player move) takes priority over expiry.
    assign expired = enable && !clear && (count_q == LIMIT - 1);

    always_comb begin
        count_d = count_q;
        if (clear || expired) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/connect4_turn_controller.sv
// Connect4 game sequencer: takes column requests, issues one drop at a time,
// runs a win check after each placed token, then alternates turns or ends the game.
module connect4_turn_controller #(
    parameter int unsigned CELLS_NUMBER = connect4_pkg::CELLS_NUMBER,
    parameter int unsigned NUM_COLS     = connect4_pkg::NUM_COLS,
    parameter int unsigned TURN_TIMEOUT = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       move_valid,
    input  logic [2:0] move_col,
    input  logic       drop_ack,
    input  logic       drop_invalid,
    input  logic       win_valid,
    input  logic       win_found,
    output logic [1:0] state,
    output logic       board_clear,
    output logic       drop_req,
    output logic [2:0] drop_col,
    output logic       drop_player,
    output logic       chk_req,
    output logic       busy,
    output logic       err_pulse,
    output logic [1:0] winner,
    output logic [5:0] move_count
);

    import connect4_pkg::*;

    game_state_e state_q, state_d;
    phase_e      phase_q, phase_d;
    logic        board_clear_q, board_clear_d;
    logic        drop_req_q, drop_req_d;
    logic [2:0]  drop_col_q, drop_col_d;
    logic        drop_player_q, drop_player_d;
    logic        chk_req_q, chk_req_d;
    logic        busy_q, busy_d;
    logic        err_pulse_q, err_pulse_d;
    logic [1:0]  winner_q, winner_d;
    logic [5:0]  move_count_q, move_count_d;
    logic        timer_expired;

    generate
        if (TURN_TIMEOUT > 0) begin : g_timer
            turn_timer #(.LIMIT(TURN_TIMEOUT)) u_turn_timer (
                .clk     (clk),
                .reset   (reset),
                .clear   ((phase_q != PH_WAIT_MOVE) || move_valid),
                .enable  (phase_q == PH_WAIT_MOVE),
                .expired (timer_expired)
            );
        end else begin : g_no_timer
            assign timer_expired = 1'b0;
        end
    endgenerate

    // NOTE: every variable gets its hold/idle value first so no path infers a latch.
    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        board_clear_d = 1'b0;
        drop_req_d    = drop_req_q;
        drop_col_d    = drop_col_q;
        drop_player_d = drop_player_q;
        chk_req_d     = chk_req_q;
        err_pulse_d   = 1'b0;
        winner_d      = winner_q;
        move_count_d  = move_count_q;

        case (phase_q)
            PH_IDLE: begin
                if (start) begin
                    board_clear_d = 1'b1;
                    move_count_d  = '0;
                    winner_d      = WIN_NONE;
                    state_d       = P1_TURN;
                    phase_d       = PH_WAIT_MOVE;
                end
            end
            PH_WAIT_MOVE: begin
                if (move_valid) begin
                    if (32'(move_col) < NUM_COLS) begin
                        drop_req_d    = 1'b1;
                        drop_col_d    = move_col;
                        drop_player_d = (state_q == P2_TURN);
                        phase_d       = PH_DROP;
                    end else begin
                        err_pulse_d = 1'b1;
                    end
                end else if (timer_expired) begin
                    err_pulse_d = 1'b1;
                    state_d     = other_player(state_q);
                end
            end
            PH_DROP: begin
                // A full column outranks a simultaneous ack: the token was not placed.
                if (drop_invalid) begin
                    drop_req_d  = 1'b0;
                    err_pulse_d = 1'b1;
                    phase_d     = PH_WAIT_MOVE;
                end else if (drop_ack) begin
                    drop_req_d = 1'b0;
                    chk_req_d  = 1'b1;
                    phase_d    = PH_CHECK;
                    if (move_count_q < 6'(CELLS_NUMBER)) begin
                        move_count_d = move_count_q + 6'd1;
                    end
                end
            end
            PH_CHECK: begin
                if (win_valid) begin
                    chk_req_d = 1'b0;
                    if (win_found) begin
                        winner_d = drop_player_q ? WIN_P2 : WIN_P1;
                        state_d  = END_GAME;
                        phase_d  = PH_IDLE;
                    end else if (move_count_q == 6'(CELLS_NUMBER)) begin
                        winner_d = WIN_DRAW;
                        state_d  = END_GAME;
                        phase_d  = PH_IDLE;
                    end else begin
                        state_d = other_player(state_q);
                        phase_d = PH_WAIT_MOVE;
                    end
                end
            end
            default: ;
        endcase

        busy_d = (phase_d == PH_DROP) || (phase_d == PH_CHECK);
    end

    // NOTE: reset is sampled on the clock edge; all state uses non-blocking updates.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= GAME_INIT;
            phase_q       <= PH_IDLE;
            board_clear_q <= 1'b0;
            drop_req_q    <= 1'b0;
            drop_col_q    <= '0;
            drop_player_q <= 1'b0;
            chk_req_q     <= 1'b0;
            busy_q        <= 1'b0;
            err_pulse_q   <= 1'b0;
            winner_q      <= WIN_NONE;
            move_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            board_clear_q <= board_clear_d;
            drop_req_q    <= drop_req_d;
            drop_col_q    <= drop_col_d;
            drop_player_q <= drop_player_d;
            chk_req_q     <= chk_req_d;
            busy_q        <= busy_d;
            err_pulse_q   <= err_pulse_d;
            winner_q      <= winner_d;
            move_count_q  <= move_count_d;
        end
    end

    assign state       = state_q;
    assign board_clear = board_clear_q;
    assign drop_req    = drop_req_q;
    assign drop_col    = drop_col_q;
    assign drop_player = drop_player_q;
    assign chk_req     = chk_req_q;
    assign busy        = busy_q;
    assign err_pulse   = err_pulse_q;
    assign winner      = winner_q;
    assign move_count  = move_count_q;

endmodule

// File: tb/tb_connect4_turn_controller.sv
// Directed bench for connect4_turn_controller: a game-level model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_connect4_turn_controller;

    localparam int TIMEOUT = 10;

    logic       clk = 1'b0;
    logic       reset, start, move_valid, drop_ack, drop_invalid, win_valid, win_found;
    logic [2:0] move_col;
    logic [1:0] state, winner;
    logic       board_clear, drop_req, drop_player, chk_req, busy, err_pulse;
    logic [2:0] drop_col;
    logic [5:0] move_count;

    int n_checks = 0;
    int n_pass   = 0;
    logic cmp_en = 1'b0;

    always #5 clk = ~clk;

    connect4_turn_controller #(.TURN_TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .move_valid   (move_valid),
        .move_col     (move_col),
        .drop_ack     (drop_ack),
        .drop_invalid (drop_invalid),
        .win_valid    (win_valid),
        .win_found    (win_found),
        .state        (state),
        .board_clear  (board_clear),
        .drop_req     (drop_req),
        .drop_col     (drop_col),
        .drop_player  (drop_player),
        .chk_req      (chk_req),
        .busy         (busy),
        .err_pulse    (err_pulse),
        .winner       (winner),
        .move_count   (move_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Game-level model: who is to move, what request is outstanding, tokens placed.
    logic       m_in_game, m_over, m_turn, m_drop_pend, m_chk_pend, m_clear, m_err;
    logic [2:0] m_col;
    logic [1:0] m_winner;
    int         m_count, m_idle;

    always @(posedge clk) begin
        m_clear <= 1'b0;
        m_err   <= 1'b0;
        if (reset) begin
            m_in_game <= 0; m_over <= 0; m_turn <= 0; m_drop_pend <= 0; m_chk_pend <= 0;
            m_col <= 0; m_winner <= 0; m_count <= 0; m_idle <= 0;
        end else if (!m_in_game) begin
            if (start) begin
                m_in_game <= 1; m_turn <= 0; m_count <= 0; m_winner <= 0;
                m_clear <= 1; m_idle <= 0;
            end
        end else if (m_drop_pend) begin
            if (drop_invalid) begin
                m_drop_pend <= 0; m_err <= 1; m_idle <= 0;
            end else if (drop_ack) begin
                m_drop_pend <= 0; m_chk_pend <= 1;
                m_count <= (m_count < 42) ? m_count + 1 : 42;
            end
        end else if (m_chk_pend) begin
            if (win_valid) begin
                m_chk_pend <= 0; m_idle <= 0;
                if (win_found) begin
                    m_winner <= m_turn ? 2'd2 : 2'd1; m_in_game <= 0; m_over <= 1;
                end else if (m_count == 42) begin
                    m_winner <= 2'd3; m_in_game <= 0; m_over <= 1;
                end else begin
                    m_turn <= !m_turn;
                end
            end
        end else begin
            if (move_valid) begin
                m_idle <= 0;
                if (move_col < 3'd7) begin
                    m_drop_pend <= 1; m_col <= move_col;
                end else begin
                    m_err <= 1;
                end
            end else if (m_idle + 1 == TIMEOUT) begin
                m_err <= 1; m_turn <= !m_turn; m_idle <= 0;
            end else begin
                m_idle <= m_idle + 1;
            end
        end
    end

    always @(negedge clk) begin
        logic [1:0]  exp_state;
        logic [14:0] exp_vec;
        if (cmp_en) begin
            exp_state = m_in_game ? (m_turn ? 2'd2 : 2'd1) : (m_over ? 2'd3 : 2'd0);
            exp_vec = {exp_state, m_clear, m_drop_pend, m_chk_pend, m_drop_pend | m_chk_pend,
                       m_err, m_winner, 6'(m_count)};
            check("model_outputs", {17'd0, state, board_clear, drop_req, chk_req, busy,
                                    err_pulse, winner, move_count}, {17'd0, exp_vec});
            if (m_drop_pend)
                check("model_drop_target", {28'd0, drop_col, drop_player}, {28'd0, m_col, m_turn});
        end
    end

    task automatic start_game();
        start = 1; @(negedge clk); start = 0;
    endtask
    task automatic move(input logic [2:0] col);
        move_valid = 1; move_col = col; @(negedge clk); move_valid = 0; move_col = 0;
    endtask
    task automatic ack();
        drop_ack = 1; @(negedge clk); drop_ack = 0;
    endtask
    task automatic reject();
        drop_invalid = 1; @(negedge clk); drop_invalid = 0;
    endtask
    task automatic win(input logic found);
        win_valid = 1; win_found = found; @(negedge clk); win_valid = 0; win_found = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; start = 0; move_valid = 0; move_col = 0; drop_ack = 0;
        drop_invalid = 0; win_valid = 0; win_found = 0;
        @(negedge clk);
        cmp_en = 1;
        @(negedge clk);
        reset = 0;
        check("reset_outputs", {13'd0, state, board_clear, drop_req, drop_col, drop_player,
                                chk_req, busy, err_pulse, winner, move_count}, 32'd0);

        start_game();
        check("start_clear_pulse", {31'd0, board_clear}, 32'd1);
        check("start_state", {30'd0, state}, 32'd1);
        @(negedge clk);
        check("clear_one_cycle", {31'd0, board_clear}, 32'd0);

        move(3);
        check("first_drop", {27'd0, drop_req, drop_col, drop_player}, {27'd0, 1'b1, 3'd3, 1'b0});
        move(5);
        check("no_second_drop", {28'd0, drop_req, drop_col}, {28'd0, 1'b1, 3'd3});
        ack();
        check("ack_to_check", {24'd0, drop_req, chk_req, move_count}, {24'd0, 1'b0, 1'b1, 6'd1});
        win(0);
        check("p1_no_win_state", {30'd0, state}, 32'd2);

        move(2);
        check("p2_player", {31'd0, drop_player}, 32'd1);
        ack();
        win(0);
        check("p2_no_win", {24'd0, state, move_count}, {24'd0, 2'd1, 6'd2});

        start_game();
        check("start_ignored", {29'd0, board_clear, state}, {29'd0, 1'b0, 2'd1});

        move(0);
        reject();
        check("full_column", {22'd0, err_pulse, drop_req, state, move_count},
              {22'd0, 1'b1, 1'b0, 2'd1, 6'd2});
        @(negedge clk);
        check("err_one_cycle", {31'd0, err_pulse}, 32'd0);

        move(7);
        check("illegal_column", {28'd0, err_pulse, drop_req, state}, {28'd0, 1'b1, 1'b0, 2'd1});
        move(1); ack(); win(0);
        move(4); ack(); win(1);
        check("p2_wins", {24'd0, state, winner, move_count}, {24'd0, 2'd3, 2'd2, 6'd4});

        start_game();
        check("new_game", {22'd0, state, winner, move_count, board_clear},
              {22'd0, 2'd1, 2'd0, 6'd0, 1'b1});

        for (int i = 0; i < 42; i++) begin
            move(3'(i % 7)); ack(); win(0);
        end
        check("draw", {22'd0, state, winner, move_count}, {22'd0, 2'd3, 2'd3, 6'd42});

        start_game();
        repeat (TIMEOUT - 1) @(negedge clk);
        check("before_timeout", {29'd0, err_pulse, state}, {29'd0, 1'b0, 2'd1});
        @(negedge clk);
        check("timeout", {26'd0, err_pulse, state, move_count}, {26'd0, 1'b1, 2'd2, 6'd0});
        repeat (TIMEOUT - 1) @(negedge clk);
        move(2);
        check("move_beats_timeout", {28'd0, err_pulse, drop_req, state}, {28'd0, 1'b0, 1'b1, 2'd2});
        ack(); win(0);
        check("after_timeout_move", {24'd0, state, move_count}, {24'd0, 2'd1, 6'd1});

        move(5); ack();
        check("in_check", {31'd0, chk_req}, 32'd1);
        reset = 1; @(negedge clk); reset = 0;
        check("reset_in_check", {13'd0, state, board_clear, drop_req, drop_col, drop_player,
                                 chk_req, busy, err_pulse, winner, move_count}, 32'd0);
        drop_ack = 1; win_valid = 1; @(negedge clk); drop_ack = 0; win_valid = 0;
        check("late_ack_ignored", {22'd0, state, chk_req, busy, move_count}, 32'd0);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
